// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter
//
// Round-robin arbiter sharing one bsg_cache-style DMA port among num_req_p
// requesters. One transaction is in flight at a time. The granted requester's
// packet is forwarded downstream. Exactly burst_len_p data beats are then
// steered in the packet's direction before the next arbitration.
//
// Ports
//   clk_i, reset_i                  core clock, synchronous active-high reset
//   dma_pkt_i/_v_i/_yumi_o          per-requester packet {write_not_read, addr}
//   dma_data_i/_v_i/_yumi_o         per-requester write data
//   dma_data_o/_v_o/_ready_and_i    read data (broadcast) with per-requester valid
//   mem_dma_pkt_o/_v_o/_yumi_i      downstream packet channel
//   mem_dma_data_o/_v_o/_yumi_i     downstream write-data channel
//   mem_dma_data_i/_v_i/_ready_and_o downstream read-data channel
module dma_channel_arbiter #(
  parameter int num_req_p     = 2,
  parameter int caddr_width_p = 28,
  parameter int data_width_p  = 64,
  parameter int burst_len_p   = 8,
  localparam int dma_pkt_width_lp = 1 + caddr_width_p
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,

  input  logic [num_req_p*dma_pkt_width_lp-1:0] dma_pkt_i,
  input  logic [num_req_p-1:0]                  dma_pkt_v_i,
  output logic [num_req_p-1:0]                  dma_pkt_yumi_o,

  input  logic [num_req_p*data_width_p-1:0]     dma_data_i,
  input  logic [num_req_p-1:0]                  dma_data_v_i,
  output logic [num_req_p-1:0]                  dma_data_yumi_o,

  output logic [data_width_p-1:0]               dma_data_o,
  output logic [num_req_p-1:0]                  dma_data_v_o,
  input  logic [num_req_p-1:0]                  dma_data_ready_and_i,

  output logic [dma_pkt_width_lp-1:0]           mem_dma_pkt_o,
  output logic                                  mem_dma_pkt_v_o,
  input  logic                                  mem_dma_pkt_yumi_i,

  output logic [data_width_p-1:0]               mem_dma_data_o,
  output logic                                  mem_dma_data_v_o,
  input  logic                                  mem_dma_data_yumi_i,

  input  logic [data_width_p-1:0]               mem_dma_data_i,
  input  logic                                  mem_dma_data_v_i,
  output logic                                  mem_dma_data_ready_and_o
);

  localparam int ptr_w_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int beat_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam logic [num_req_p-1:0] unit_lp = num_req_p'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWrite, StRead} state_e;

  state_e               state_r;
  logic [ptr_w_lp-1:0]  rr_ptr_r;
  logic [ptr_w_lp-1:0]  grant_r;
  logic [beat_w_lp-1:0] beat_r;

  logic [num_req_p-1:0]        w_grant_oh;
  logic [dma_pkt_width_lp-1:0] w_pkt_sel;
  logic [data_width_p-1:0]     w_data_sel;
  logic                        w_found;
  logic [ptr_w_lp-1:0]         w_pick;
  logic [ptr_w_lp-1:0]         w_next_ptr;
  logic                        w_beat_fire;
  logic                        w_last_beat;

  // One-hot form of grant_r avoids variable bit-selects on narrow vectors.
  assign w_grant_oh = unit_lp << grant_r;
  assign w_pkt_sel  = dma_pkt_i[int'(grant_r)*dma_pkt_width_lp +: dma_pkt_width_lp];
  assign w_data_sel = dma_data_i[int'(grant_r)*data_width_p +: data_width_p];

  // First valid requester at or after rr_ptr_r, wrapping around.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_pick  = rr_ptr_r;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!w_found && |(dma_pkt_v_i & (unit_lp << idx))) begin
        w_found = 1'b1;
        w_pick  = ptr_w_lp'(idx);
      end
    end
  end

  assign w_next_ptr  = (int'(grant_r) == num_req_p - 1) ? '0 : grant_r + 1'b1;
  assign w_last_beat = (beat_r == beat_w_lp'(burst_len_p - 1));
  assign w_beat_fire = ((state_r == StWrite) && mem_dma_data_yumi_i)
                    || ((state_r == StRead) && mem_dma_data_v_i && mem_dma_data_ready_and_o);

  assign mem_dma_pkt_o  = w_pkt_sel;
  assign mem_dma_data_o = w_data_sel;
  assign dma_data_o     = mem_dma_data_i;

  // Handshake steering: only the granted requester in its current phase sees activity.
  always_comb begin
    dma_pkt_yumi_o           = '0;
    dma_data_yumi_o          = '0;
    dma_data_v_o             = '0;
    mem_dma_pkt_v_o          = 1'b0;
    mem_dma_data_v_o         = 1'b0;
    mem_dma_data_ready_and_o = 1'b0;
    case (state_r)
      StIssue: begin
        mem_dma_pkt_v_o = |(dma_pkt_v_i & w_grant_oh);
        dma_pkt_yumi_o  = w_grant_oh & {num_req_p{mem_dma_pkt_yumi_i}};
      end
      StWrite: begin
        mem_dma_data_v_o = |(dma_data_v_i & w_grant_oh);
        dma_data_yumi_o  = w_grant_oh & {num_req_p{mem_dma_data_yumi_i}};
      end
      StRead: begin
        dma_data_v_o             = w_grant_oh & {num_req_p{mem_dma_data_v_i}};
        mem_dma_data_ready_and_o = |(dma_data_ready_and_i & w_grant_oh);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= StIdle;
      rr_ptr_r <= '0;
      grant_r  <= '0;
      beat_r   <= '0;
    end else begin
      case (state_r)
        StIdle: begin
          if (w_found) begin
            grant_r <= w_pick;
            state_r <= StIssue;
          end
        end
        StIssue: begin
          if (mem_dma_pkt_yumi_i) begin
            state_r <= w_pkt_sel[dma_pkt_width_lp-1] ? StWrite : StRead;
          end
        end
        StWrite, StRead: begin
          if (w_beat_fire) begin
            if (w_last_beat) begin
              beat_r   <= '0;
              rr_ptr_r <= w_next_ptr;
              state_r  <= StIdle;
            end else begin
              beat_r <= beat_r + 1'b1;
            end
          end
        end
        default: state_r <= StIdle;
      endcase
    end
  end

  // Protocol checks on the requester and downstream sides.
  a_pkt_v_held: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_r == StIssue) |-> |(dma_pkt_v_i & w_grant_oh));
  a_rd_v_phase: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_dma_data_v_i |-> (state_r == StRead));
  a_wr_yumi_phase: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_dma_data_yumi_i |-> (state_r == StWrite));

endmodule

// File: tb/tb_dma_channel_arbiter.sv
module tb_dma_channel_arbiter;
  localparam int N = 2;
  localparam int A = 28;
  localparam int D = 64;
  localparam int B = 8;
  localparam int W = A + 1;

  logic clk = 1'b0;
  logic reset_i = 1'b1;

  logic [N*W-1:0] dma_pkt_i = '0;
  logic [N-1:0]   dma_pkt_v_i = '0;
  logic [N-1:0]   dma_pkt_yumi_o;
  logic [N*D-1:0] dma_data_i = '0;
  logic [N-1:0]   dma_data_v_i = '0;
  logic [N-1:0]   dma_data_yumi_o;
  logic [D-1:0]   dma_data_o;
  logic [N-1:0]   dma_data_v_o;
  logic [N-1:0]   dma_data_ready_and_i = '0;
  logic [W-1:0]   mem_dma_pkt_o;
  logic           mem_dma_pkt_v_o;
  logic           mem_dma_pkt_yumi_i = 1'b0;
  logic [D-1:0]   mem_dma_data_o;
  logic           mem_dma_data_v_o;
  logic           mem_dma_data_yumi_i = 1'b0;
  logic [D-1:0]   mem_dma_data_i = '0;
  logic           mem_dma_data_v_i = 1'b0;
  logic           mem_dma_data_ready_and_o;

  // Single-requester, single-beat instance.
  logic [W-1:0] s_pkt = '0;
  logic         s_pkt_v = 1'b0;
  logic         s_pkt_yumi_o;
  logic [D-1:0] s_data = '0;
  logic         s_data_v = 1'b0;
  logic         s_data_yumi_o;
  logic [D-1:0] s_rdata_o;
  logic         s_rdata_v_o;
  logic [W-1:0] s_mem_pkt_o;
  logic         s_mem_pkt_v_o;
  logic         s_mem_pkt_yumi = 1'b0;
  logic [D-1:0] s_mem_data_o;
  logic         s_mem_data_v_o;
  logic         s_mem_data_yumi = 1'b0;
  logic         s_mem_rdy_o;

  int total = 0;
  int bad = 0;
  logic [D-1:0] exp_q[$];

  always #5 clk = ~clk;

  dma_channel_arbiter #(
    .num_req_p(N), .caddr_width_p(A), .data_width_p(D), .burst_len_p(B)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o),
    .dma_data_ready_and_i(dma_data_ready_and_i),
    .mem_dma_pkt_o(mem_dma_pkt_o), .mem_dma_pkt_v_o(mem_dma_pkt_v_o),
    .mem_dma_pkt_yumi_i(mem_dma_pkt_yumi_i),
    .mem_dma_data_o(mem_dma_data_o), .mem_dma_data_v_o(mem_dma_data_v_o),
    .mem_dma_data_yumi_i(mem_dma_data_yumi_i),
    .mem_dma_data_i(mem_dma_data_i), .mem_dma_data_v_i(mem_dma_data_v_i),
    .mem_dma_data_ready_and_o(mem_dma_data_ready_and_o)
  );

  dma_channel_arbiter #(
    .num_req_p(1), .caddr_width_p(A), .data_width_p(D), .burst_len_p(1)
  ) dut_s (
    .clk_i(clk), .reset_i(reset_i),
    .dma_pkt_i(s_pkt), .dma_pkt_v_i(s_pkt_v), .dma_pkt_yumi_o(s_pkt_yumi_o),
    .dma_data_i(s_data), .dma_data_v_i(s_data_v), .dma_data_yumi_o(s_data_yumi_o),
    .dma_data_o(s_rdata_o), .dma_data_v_o(s_rdata_v_o), .dma_data_ready_and_i(1'b0),
    .mem_dma_pkt_o(s_mem_pkt_o), .mem_dma_pkt_v_o(s_mem_pkt_v_o),
    .mem_dma_pkt_yumi_i(s_mem_pkt_yumi),
    .mem_dma_data_o(s_mem_data_o), .mem_dma_data_v_o(s_mem_data_v_o),
    .mem_dma_data_yumi_i(s_mem_data_yumi),
    .mem_dma_data_i('0), .mem_dma_data_v_i(1'b0), .mem_dma_data_ready_and_o(s_mem_rdy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] one;
    one = N'(1);
    return one << g;
  endfunction

  function automatic logic [D-1:0] wbeat(input int k);
    return {32'(k), 32'hDEADBEEF};
  endfunction

  function automatic logic [D-1:0] rbeat(input int k);
    return {32'hC0DE0000 + 32'(k), 32'h5A5A5A5A ^ 32'(k)};
  endfunction

  task automatic set_pkt(input int g, input logic [W-1:0] p, input logic v);
    dma_pkt_i[g*W +: W] = p;
    dma_pkt_v_i[g] = v;
  endtask

  // One full transaction for expected grantee g, starting in an IDLE cycle with the
  // requests already presented. hold: cycles of downstream packet backpressure;
  // gap: write yumi every other cycle; stall_at: read beat where ready drops for
  // 3 cycles; abort_at: stop the write after that many beats (no completion).
  task automatic xact(input int g, input int hold, input bit gap, input int stall_at,
                      input int abort_at);
    logic [W-1:0] p;
    int k, cyc, pushed, st;
    bit y, r;
    p = dma_pkt_i[g*W +: W];
    samp();
    chk("idle_pkt_v", 64'(mem_dma_pkt_v_o), 0);
    chk("idle_pkt_yumi", 64'(dma_pkt_yumi_o), 0);
    step();
    for (int h = 0; h < hold; h++) begin
      samp();
      chk("hold_pkt_v", 64'(mem_dma_pkt_v_o), 1);
      chk("hold_pkt", 64'(mem_dma_pkt_o), 64'(p));
      chk("hold_pkt_yumi", 64'(dma_pkt_yumi_o), 0);
      step();
    end
    mem_dma_pkt_yumi_i = 1'b1;
    samp();
    chk("issue_pkt_v", 64'(mem_dma_pkt_v_o), 1);
    chk("issue_pkt", 64'(mem_dma_pkt_o), 64'(p));
    chk("issue_pkt_yumi", 64'(dma_pkt_yumi_o), 64'(oh(g)));
    step();
    mem_dma_pkt_yumi_i = 1'b0;
    k = 0;
    cyc = 0;
    pushed = 0;
    st = 0;
    if (p[W-1]) begin
      for (int i = 0; i < B; i++) exp_q.push_back(wbeat(i));
      while (k < B && cyc < 4 * B && k != abort_at) begin
        dma_data_i[g*D +: D] = wbeat(k);
        dma_data_v_i[g] = 1'b1;
        y = !gap || (cyc % 2 == 1);
        mem_dma_data_yumi_i = y;
        samp();
        chk("wr_v", 64'(mem_dma_data_v_o), 1);
        chk("wr_yumi", 64'(dma_data_yumi_o), y ? 64'(oh(g)) : 64'd0);
        chk("rd_v_quiet", 64'(dma_data_v_o), 0);
        if (y) begin
          chk("wr_data", mem_dma_data_o, exp_q.pop_front());
          k++;
        end
        cyc++;
        step();
      end
      mem_dma_data_yumi_i = 1'b0;
      dma_data_v_i[g] = 1'b0;
    end else begin
      while (k < B && cyc < 4 * B) begin
        if (pushed == k) begin
          exp_q.push_back(rbeat(k));
          pushed++;
        end
        mem_dma_data_i = rbeat(k);
        mem_dma_data_v_i = 1'b1;
        r = !(k == stall_at && st < 3);
        if (!r) st++;
        dma_data_ready_and_i[g] = r;
        samp();
        chk("rd_v", 64'(dma_data_v_o), 64'(oh(g)));
        chk("rd_rdy", 64'(mem_dma_data_ready_and_o), 64'(r));
        chk("wr_yumi_quiet", 64'(dma_data_yumi_o), 0);
        if (r) begin
          chk("rd_data", dma_data_o, exp_q.pop_front());
          k++;
        end
        cyc++;
        step();
      end
      mem_dma_data_v_i = 1'b0;
      dma_data_ready_and_i[g] = 1'b0;
    end
    if (k == abort_at) exp_q.delete();
    else chk("beat_count", 64'(k), 64'(B));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_pkt_v"}, 64'(mem_dma_pkt_v_o), 0);
    chk({tag, "_data_v"}, 64'(mem_dma_data_v_o), 0);
    chk({tag, "_rdy"}, 64'(mem_dma_data_ready_and_o), 0);
    chk({tag, "_pkt_yumi"}, 64'(dma_pkt_yumi_o), 0);
    chk({tag, "_data_yumi"}, 64'(dma_data_yumi_o), 0);
    chk({tag, "_rd_v"}, 64'(dma_data_v_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    step();
    samp();
    chk_quiet("rst");
    chk("rst_s_pkt_v", 64'(s_mem_pkt_v_o), 0);
    chk("rst_s_data_v", 64'(s_mem_data_v_o), 0);
    step();
    reset_i = 1'b0;

    // Single write from requester 0.
    set_pkt(0, {1'b1, 28'h100}, 1'b1);
    xact(0, 0, 1'b0, -1, -1);
    set_pkt(0, '0, 1'b0);

    // Read back to requester 1 with a 3-cycle ready stall mid-burst.
    set_pkt(1, {1'b0, 28'h100}, 1'b1);
    xact(1, 0, 1'b0, 3, -1);
    set_pkt(1, '0, 1'b0);

    // Simultaneous continuous requests after reset: grants alternate 0,1,0,1.
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    set_pkt(0, {1'b0, 28'h200}, 1'b1);
    set_pkt(1, {1'b0, 28'h300}, 1'b1);
    xact(0, 0, 1'b0, -1, -1);
    xact(1, 0, 1'b0, -1, -1);
    xact(0, 0, 1'b0, -1, -1);
    xact(1, 0, 1'b0, -1, -1);
    set_pkt(0, '0, 1'b0);
    set_pkt(1, '0, 1'b0);

    // Downstream packet backpressure, then a write with yumi every other cycle.
    set_pkt(0, {1'b1, 28'h400}, 1'b1);
    xact(0, 10, 1'b1, -1, -1);
    set_pkt(0, '0, 1'b0);

    // Reset after beat 3 of a write; pointer is 1 here, reset must return it to 0.
    set_pkt(0, {1'b1, 28'h500}, 1'b1);
    xact(0, 0, 1'b0, -1, 3);
    set_pkt(0, '0, 1'b0);
    dma_data_v_i[0] = 1'b1;
    mem_dma_data_yumi_i = 1'b1;
    reset_i = 1'b1;
    step();
    samp();
    chk_quiet("midrst");
    step();
    mem_dma_data_yumi_i = 1'b0;
    dma_data_v_i[0] = 1'b0;
    reset_i = 1'b0;
    set_pkt(0, {1'b0, 28'h600}, 1'b1);
    set_pkt(1, {1'b0, 28'h700}, 1'b1);
    xact(0, 0, 1'b0, -1, -1);
    set_pkt(0, '0, 1'b0);
    xact(1, 0, 1'b0, -1, -1);
    set_pkt(1, '0, 1'b0);

    // Single requester, single-beat: back-to-back writes, 3 cycles each.
    s_pkt_v = 1'b1;
    s_data_v = 1'b1;
    for (int t = 0; t < 4; t++) begin
      s_pkt = {1'b1, 28'h800 + 28'(t * 64)};
      s_data = wbeat(100 + t);
      exp_q.push_back(s_data);
      samp();
      chk("s_idle_pkt_v", 64'(s_mem_pkt_v_o), 0);
      chk("s_idle_pkt_yumi", 64'(s_pkt_yumi_o), 0);
      step();
      s_mem_pkt_yumi = 1'b1;
      samp();
      chk("s_issue_pkt_v", 64'(s_mem_pkt_v_o), 1);
      chk("s_issue_pkt", 64'(s_mem_pkt_o), 64'(s_pkt));
      chk("s_issue_pkt_yumi", 64'(s_pkt_yumi_o), 1);
      step();
      s_mem_pkt_yumi = 1'b0;
      s_mem_data_yumi = 1'b1;
      samp();
      chk("s_wr_v", 64'(s_mem_data_v_o), 1);
      chk("s_wr_yumi", 64'(s_data_yumi_o), 1);
      chk("s_wr_data", s_mem_data_o, exp_q.pop_front());
      step();
      s_mem_data_yumi = 1'b0;
    end
    s_pkt_v = 1'b0;
    s_data_v = 1'b0;
    samp();
    chk("s_end_pkt_v", 64'(s_mem_pkt_v_o), 0);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
